// File: rtl/dense_mv_serial.sv
// Serial fixed-point dense layer: y = W*x + b, one multiply-accumulate per clock.
// One vector in flight at a time; valid/ready handshakes on input and output.
module dense_mv_serial #(
  parameter int IN_DIM    = 4,
  parameter int OUT_DIM   = 4,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_DIM*WIDTH-1:0]           in_vec,
  input  logic [OUT_DIM*IN_DIM*WIDTH-1:0]   weights_flat,
  input  logic [OUT_DIM*WIDTH-1:0]          bias_flat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_DIM*WIDTH-1:0]          out_vec,
  output logic                              busy
);

  localparam int JW = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
  localparam int IW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(IN_DIM - 1);
  localparam logic [IW-1:0] I_LAST = IW'(OUT_DIM - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                  state_q;
  logic [JW-1:0]           j_q;
  logic [IW-1:0]           i_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] x_q [IN_DIM];
  logic signed [WIDTH-1:0] y_q [OUT_DIM];
  logic                    in_ready_q, out_valid_q, busy_q;

  logic signed [WIDTH-1:0]     w_a [OUT_DIM][IN_DIM];
  logic signed [WIDTH-1:0]     b_a [OUT_DIM];
  logic signed [WIDTH-1:0]     w_sel, b_next;
  logic signed [2*WIDTH-1:0]   prod;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  // Bias is aligned to the product's 2*FRAC binary point before accumulation.
  function automatic logic signed [ACC_WIDTH-1:0] bias_load(input logic signed [WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] ext;
    ext = {{(ACC_WIDTH-WIDTH){b[WIDTH-1]}}, b};
    bias_load = ext <<< FRAC;
  endfunction

  for (genvar gi = 0; gi < OUT_DIM; gi++) begin : g_unpack_row
    assign b_a[gi] = bias_flat[gi*WIDTH +: WIDTH];
    assign out_vec[gi*WIDTH +: WIDTH] = y_q[gi];
    for (genvar gj = 0; gj < IN_DIM; gj++) begin : g_unpack_col
      assign w_a[gi][gj] = weights_flat[(gi*IN_DIM+gj)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_sel  = w_a[i_q][j_q];
    b_next = (i_q == I_LAST) ? '0 : b_a[i_q + 1'b1];
    prod   = x_q[j_q] * w_sel;
    acc_d  = acc_q + {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < IN_DIM; k++)  x_q[k] <= '0;
      for (int k = 0; k < OUT_DIM; k++) y_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < IN_DIM; k++) x_q[k] <= in_vec[k*WIDTH +: WIDTH];
            i_q        <= '0;
            j_q        <= '0;
            acc_q      <= bias_load(b_a[0]);
            state_q    <= S_MAC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_MAC: begin
          if (j_q == J_LAST) begin
            y_q[i_q] <= sat(acc_d >>> FRAC);
            acc_q    <= bias_load(b_next);
            j_q      <= '0;
            if (i_q == I_LAST) begin
              i_q         <= '0;
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            acc_q <= acc_d;
            j_q   <= j_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/dense_mv_serial.md
Name: dense_mv_serial

Overview:
- Serial fixed-point matrix-vector stage: computes y = W·x + b for one IN_DIM-element input vector, one MAC per clock.
- Sits directly upstream of the vector ReLU activation stage; out_vec uses the same packed signed layout and feeds the activation input combinationally.
- Valid/ready handshakes on both sides; processes one vector at a time, with no overlap between vectors.

Parameters:
- IN_DIM, 4, input vector length (>=1)
- OUT_DIM, 4, output vector length (>=1)
- WIDTH, 16, signed element width of x, W, b, y
- FRAC, 8, fractional bits of the Q format shared by x, W, b, y
- ACC_WIDTH, 40, signed accumulator width (>= 2*WIDTH + clog2(IN_DIM) + 1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_vec valid
- in_ready  out  1  block can accept in_vec
- in_vec  in  IN_DIM*WIDTH  signed x; element j at [j*WIDTH +: WIDTH]
- weights_flat  in  OUT_DIM*IN_DIM*WIDTH  signed W[i][j] at [(i*IN_DIM+j)*WIDTH +: WIDTH]
- bias_flat  in  OUT_DIM*WIDTH  signed b[i] at [i*WIDTH +: WIDTH]
- out_valid  out  1  out_vec valid
- out_ready  in  1  downstream accepts out_vec
- out_vec  out  OUT_DIM*WIDTH  signed y; element i at [i*WIDTH +: WIDTH]
- busy  out  1  high in MAC or DONE

Behaviour:
Reset:
- rst is synchronous and active-high, sampled on the clk edge; it overrides everything.
- After reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_vec=0, counters i=j=0, acc=0.
- Reset mid-MAC or mid-DONE aborts the vector; no partial result is ever presented.

FSM IDLE:
- in_ready=1.
- On in_valid&&in_ready (cycle T): register in_vec into x_reg, i=0, j=0, acc = sign-extended b[0] << FRAC, go to MAC.

FSM MAC (cycles T+1 .. T+N, N = IN_DIM*OUT_DIM):
- Each cycle: acc += sext(x_reg[j]) * sext(W[i][j]), using a full 2*WIDTH signed product.
- If j == IN_DIM-1:
  - y_reg[i] = sat(acc_next >>> FRAC).
  - acc reloads with sext(b[i+1]) << FRAC.
  - j=0, i++.
- Otherwise j++.
- After the row i == OUT_DIM-1 completes, go to DONE.

FSM DONE:
- out_valid=1 from cycle T+N+1. out_vec = y_reg, held stable while out_valid && !out_ready.
- On out_valid&&out_ready: go to IDLE; in_ready=1 on the next cycle.
- Earliest next accept is T+N+2. Throughput is one vector per N+2 cycles with zero backpressure.

Arithmetic:
- >>> is arithmetic right shift, so values truncate toward -inf (floor).
- sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- The accumulator never wraps, given the ACC_WIDTH constraint.

Handshake and stability rules:
- in_ready=0 in MAC and DONE. in_vec is ignored outside IDLE.
- weights_flat and bias_flat are sampled live during MAC. The upstream controller holds them stable from the accept cycle to out_valid; changes in IDLE or DONE have no effect on the current result.
- out_vec is updated only in MAC and keeps its last value after the handshake, until the next vector overwrites it.
- busy = (state != IDLE).

Degenerate sizes:
- IN_DIM=1: every MAC cycle completes a row.
- OUT_DIM=1: single output element.

Test Plan:
All scenarios use IN_DIM=2, OUT_DIM=2, WIDTH=16, FRAC=8.
1. Identity: W=[[256,0],[0,256]], b=[0,0], x=[512,-256], accepted at T, out_ready=1 -> out_valid first high at T+5, y=[512,-256], in_ready high again at T+6.
2. Bias and mix: W=[[128,128],[256,-256]], b=[128,-64], x=[256,512] -> y=[512,-320]. Negative elements remain in y for the downstream ReLU to clear.
3. Saturation and flooring:
   - W all 32767, x=[32767,32767], b=0 -> y=[32767,32767].
   - x=[-32768,-32768] -> y=[-32768,-32768].
   - W=[[1,0],[1,0]], x=[-1,0] -> y=[-1,-1] (floor, not 0).
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_vec and out_valid stable, in_ready=0, busy=1; a second in_valid is not accepted until 1 cycle after the output handshake.
5. Reset mid-operation: assert rst at T+3 for one cycle -> next cycle out_valid=0, in_ready=1, out_vec=0. A fresh vector then yields a correct result at accept+5.
6. Back-to-back: in_valid held high with 3 distinct vectors, out_ready=1 -> accepts exactly every 6 cycles, results match the reference model in order, no drops or duplicates.
